rv32m_muldiv: RTL and testbench

RV32M_MULDIV -- requirements
Module: rv32m_muldiv

---
 rtl/rv32i_types.sv | 35 +++
 rtl/rv32m_muldiv_abs.sv | 13 +
 rtl/rv32m_muldiv.sv | 165 ++++++++++++++++
 tb/tb_rv32m_muldiv.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 type definitions: M-extension funct3 encodings and the
// multiply/divide unit FSM state, plus operand-signedness helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic md_signed_a(muldiv_funct3_t f);
    return f inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_signed_b(muldiv_funct3_t f);
    return f inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_is_div(muldiv_funct3_t f);
    return f inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/rv32m_muldiv_abs.sv
// Conditional two's-complement negate; used both to take operand
// magnitudes and to restore the sign of products, quotients and remainders.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? ({WIDTH{1'b0}} - val_i) : val_i;

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// subtract-shift step per cycle on magnitudes, sign fix-up in FIX.
// Handshake: start is accepted only in IDLE/DONE and when kill is low;
// busy is high in CALC/FIX; done pulses for one cycle with result valid.
module rv32m_muldiv
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output muldiv_state_e    dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_e  state_q, state_d;
  muldiv_funct3_t op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, bmag_q, bmag_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  muldiv_funct3_t op_in;
  logic in_neg_a, in_neg_b, dz_in, ovf_in;
  logic [WIDTH-1:0] amag_in, bmag_in, quot_fix, rem_fix, fix_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0] mul_sum, div_t, div_diff;
  logic div_ge;

  assign op_in    = muldiv_funct3_t'(op);
  assign in_neg_a = md_signed_a(op_in) & a[WIDTH-1];
  assign in_neg_b = md_signed_b(op_in) & b[WIDTH-1];
  assign dz_in    = md_is_div(op_in) && (b == '0);
  assign ovf_in   = (op_in inside {MD_DIV, MD_REM}) && (a == {1'b1, {(WIDTH-1){1'b0}}})
                    && (b == '1);

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.val_i(a), .neg_i(in_neg_a), .res_o(amag_in));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.val_i(b), .neg_i(in_neg_b), .res_o(bmag_in));
  muldiv_abs #(.WIDTH(2*WIDTH)) u_abs_p (.val_i({hi_q, lo_q}), .neg_i(neg_a_q ^ neg_b_q),
                                         .res_o(prod_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_q (.val_i(lo_q), .neg_i(neg_a_q ^ neg_b_q), .res_o(quot_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_r (.val_i(hi_q), .neg_i(neg_a_q), .res_o(rem_fix));

  // Multiply: {hi,lo} holds partial product with multiplier shifting out of lo.
  // Divide: {hi,lo} holds partial remainder with quotient bits shifting into lo.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
  assign div_t    = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_t - {1'b0, bmag_q};
  assign div_ge   = div_t >= {1'b0, bmag_q};

  always_comb begin
    fix_res = rem_fix;
    if (dz_q) begin
      fix_res = (op_q inside {MD_DIV, MD_DIVU}) ? '1 : a_q;
    end else if (ovf_q) begin
      fix_res = (op_q == MD_DIV) ? a_q : '0;
    end else begin
      case (op_q)
        MD_MUL:                        fix_res = prod_fix[WIDTH-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
        MD_DIV, MD_DIVU:               fix_res = quot_fix;
        default:                       fix_res = rem_fix;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    bmag_d   = bmag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (kill) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          state_d = MD_IDLE;
          if (start) begin
            op_d    = op_in;
            a_d     = a;
            bmag_d  = bmag_in;
            hi_d    = '0;
            lo_d    = amag_in;
            neg_a_d = in_neg_a;
            neg_b_d = in_neg_b;
            dz_d    = dz_in;
            ovf_d   = ovf_in;
            cnt_d   = '0;
            state_d = (dz_in || ovf_in) ? MD_FIX : MD_CALC;
          end
        end
        MD_CALC: begin
          cnt_d = cnt_q + CW'(1);
          if (md_is_div(op_q)) begin
            hi_d = div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST) state_d = MD_FIX;
        end
        MD_FIX: begin
          result_d = fix_res;
          state_d  = MD_DONE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      a_q      <= '0;
      bmag_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      bmag_q   <= bmag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done      = (state_q == MD_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed bench for rv32m_muldiv at WIDTH=32: arithmetic vectors,
// fast paths, latency, start-while-busy, kill, reset and back-to-back issue.
module tb_rv32m_muldiv;
  import rv32i_types::*;

  logic        clk, rst, start, kill;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  muldiv_state_e dbg_state;

  int n_pass, n_total;

  rv32m_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one op and wait (bounded) for done; edges counts the
  // accepting edge as edge 1. Returns at #1 after the done edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int edges);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done) edges = -1;
    r = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else n_pass++;
    n_total++; if (dbg_state !== MD_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, MD_IDLE); else n_pass++;
  endtask

  task automatic test_first_start();
    logic [31:0] r;
    int e;
    @(negedge clk);
    rst = 1'b0;
    op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL first_start_busy: got %b expected 1", busy); else n_pass++;
    e = 1;
    while (!done && e < 100) begin @(posedge clk); #1; e++; end
    n_total++; if (result !== 32'd12 || e != 34) $display("FAIL first_start_result: got %h at edge %0d expected 0000000c at edge 34", result, e); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int e;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, e);
    n_total++; if (r !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h expected ffffffeb", r); else n_pass++;
    n_total++; if (e != 34) $display("FAIL mul_latency: got %0d expected 34", e); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (done !== 1'b0 || dbg_state !== MD_IDLE) $display("FAIL done_pulse: got done=%b state=%0d expected done=0 state=0", done, dbg_state); else n_pass++;
    run_op(3'b001, 32'h80000000, 32'h80000000, r, e);
    n_total++; if (r !== 32'h40000000 || e != 34) $display("FAIL mulh: got %h edge %0d expected 40000000 edge 34", r, e); else n_pass++;
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, e);
    n_total++; if (r !== 32'hFFFFFFFE || e != 34) $display("FAIL mulhu: got %h edge %0d expected fffffffe edge 34", r, e); else n_pass++;
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, r, e);
    n_total++; if (r !== 32'hFFFFFFFF || e != 34) $display("FAIL mulhsu: got %h edge %0d expected ffffffff edge 34", r, e); else n_pass++;
    run_op(3'b010, 32'd2, 32'hFFFFFFFF, r, e);
    n_total++; if (r !== 32'h00000001) $display("FAIL mulhsu_pos: got %h expected 00000001", r); else n_pass++;
  endtask

  task automatic test_div();
    logic [31:0] r;
    int e;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, e);
    n_total++; if (r !== 32'hFFFFFFFD || e != 34) $display("FAIL div: got %h edge %0d expected fffffffd edge 34", r, e); else n_pass++;
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, e);
    n_total++; if (r !== 32'hFFFFFFFF) $display("FAIL rem: got %h expected ffffffff", r); else n_pass++;
    run_op(3'b101, 32'hFFFFFFF9, 32'd2, r, e);
    n_total++; if (r !== 32'h7FFFFFFC) $display("FAIL divu: got %h expected 7ffffffc", r); else n_pass++;
    run_op(3'b111, 32'hFFFFFFF9, 32'd2, r, e);
    n_total++; if (r !== 32'h00000001) $display("FAIL remu: got %h expected 00000001", r); else n_pass++;
    run_op(3'b110, 32'd7, 32'hFFFFFFFE, r, e);
    n_total++; if (r !== 32'h00000001) $display("FAIL rem_neg_b: got %h expected 00000001", r); else n_pass++;
  endtask

  task automatic test_fast_path();
    logic [31:0] r;
    int e;
    run_op(3'b101, 32'd5, 32'd0, r, e);
    n_total++; if (r !== 32'hFFFFFFFF || e != 2) $display("FAIL divu_by_zero: got %h edge %0d expected ffffffff edge 2", r, e); else n_pass++;
    run_op(3'b110, 32'd5, 32'd0, r, e);
    n_total++; if (r !== 32'd5 || e != 2) $display("FAIL rem_by_zero: got %h edge %0d expected 00000005 edge 2", r, e); else n_pass++;
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, e);
    n_total++; if (r !== 32'h80000000 || e != 2) $display("FAIL div_overflow: got %h edge %0d expected 80000000 edge 2", r, e); else n_pass++;
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, e);
    n_total++; if (r !== 32'h0 || e != 2) $display("FAIL rem_overflow: got %h edge %0d expected 00000000 edge 2", r, e); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int e;
    logic saw_done;
    @(posedge clk); #1;
    op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    a = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'd3;
    e = 10;
    while (!done && e < 100) begin @(posedge clk); #1; e++; end
    n_total++; if (result !== 32'd12 || e != 34) $display("FAIL start_ignored: got %h edge %0d expected 0000000c edge 34", result, e); else n_pass++;
    @(posedge clk); #1;
    // kill the second op at its 10th edge
    op = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL kill_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (result !== 32'd12) $display("FAIL kill_result: got %h expected 0000000c", result); else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b0) $display("FAIL kill_no_done: got %b expected 0", saw_done); else n_pass++;
    kill = 1'b1; start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    n_total++; if (busy !== 1'b0 || dbg_state !== MD_IDLE) $display("FAIL kill_priority: got busy=%b state=%0d expected busy=0 state=0", busy, dbg_state); else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [31:0] r;
    int e;
    op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_flags: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL rst_mid_result: got %h expected 00000000", result); else n_pass++;
    n_total++; if (dbg_state !== MD_IDLE) $display("FAIL rst_mid_state: got %0d expected 0", dbg_state); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b000, 32'd6, 32'd7, r, e);
    n_total++; if (r !== 32'd42 || e != 34) $display("FAIL rst_recovery: got %h edge %0d expected 0000002a edge 34", r, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int e;
    @(posedge clk); #1;
    run_op(3'b000, 32'd3, 32'd4, r, e);
    n_total++; if (r !== 32'd12) $display("FAIL b2b_first: got %h expected 0000000c", r); else n_pass++;
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done); else n_pass++;
    n_total++; if (result !== 32'd12) $display("FAIL b2b_hold: got %h expected 0000000c", result); else n_pass++;
    e = 1;
    while (!done && e < 100) begin @(posedge clk); #1; e++; end
    n_total++; if (result !== 32'd14 || e != 34) $display("FAIL b2b_second: got %h edge %0d expected 0000000e edge 34", result, e); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_first_start();
    test_mul();
    test_div();
    test_fast_path();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
